// File: rtl/ahb_tx_slave_p.sv
// AHB-Lite slave front end for a TX byte buffer: software writes bytes through
// the data window, a serialiser feeds them to the buffer one byte per cycle.
module ahb_tx_slave_p #(
    parameter int BUF_DEPTH = 64,
    parameter int OCC_W     = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             hsel,
    input  logic [3:0]       haddr,
    input  logic [1:0]       htrans,
    input  logic [2:0]       hsize,
    input  logic             hwrite,
    input  logic [31:0]      hwdata,
    output logic [31:0]      hrdata,
    output logic             hready,
    output logic             hresp,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic             tx_transfer_active,
    input  logic             tx_error,
    output logic             store_tx_data,
    output logic [7:0]       tx_data,
    output logic             clear,
    output logic [2:0]       tx_packet,
    output logic             dmode
);

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

    localparam logic [OCC_W-1:0] DEPTH_LIMIT = OCC_W'(BUF_DEPTH);

    ser_state_t  ser_state;
    ser_state_t  ser_next;
    logic [31:0] ser_shift;
    logic [2:0]  ser_count;

    logic        dp_valid;
    logic        dp_err;
    logic        err_second;
    logic        dp_write;
    logic [3:0]  dp_addr;
    logic [2:0]  dp_size;

    logic [2:0]  pkt_reg;
    logic        flush_reg;
    logic        err_reg;
    logic        active_q;

    logic        space_avail;
    logic        store_fire;
    logic        last_store;
    logic        dp_legal;
    logic        stall;
    logic        accept;
    logic        complete;
    logic        wr_commit;
    logic        wr_tx;
    logic        wr_pkt;
    logic        wr_flush;
    logic        rd_err;
    logic [3:0]  lane_en;
    logic [31:0] occ_ext;
    logic [7:0]  reg_bytes [16];

    function automatic logic is_illegal(input logic [3:0] a, input logic [2:0] s,
                                        input logic w);
        logic bad;
        bad = 1'b0;
        if (a inside {4'd9, 4'd10, 4'd11, 4'd14, 4'd15}) bad = 1'b1;
        if (w && (a >= 4'd4) && (a <= 4'd8)) bad = 1'b1;
        if (s > 3'd2) bad = 1'b1;
        if ((s == 3'd1) && a[0]) bad = 1'b1;
        if ((s == 3'd2) && (a[1:0] != 2'b00)) bad = 1'b1;
        if (w && ((a == 4'd12) || (a == 4'd13)) && (s != 3'd0)) bad = 1'b1;
        return bad;
    endfunction

    assign space_avail = (buffer_occupancy < DEPTH_LIMIT);
    assign store_fire  = (ser_state == SER_SEND) && space_avail;
    assign last_store  = store_fire && (ser_count == 3'd1);
    assign dp_legal    = dp_valid && !dp_err;

    // A data-window access waits only while the serialiser still has bytes left
    // after this cycle, so a back-to-back write loads in the cycle it drains.
    assign stall = dp_legal && (dp_addr[3:2] == 2'b00) &&
                   (ser_state == SER_SEND) && !last_store;

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        if (dp_valid && dp_err) begin
            hresp  = 1'b1;
            hready = err_second;
        end else if (stall) begin
            hready = 1'b0;
        end
    end

    assign accept    = hsel && htrans[1] && hready;
    assign complete  = dp_legal && hready;
    assign wr_commit = complete && dp_write;
    assign wr_tx     = wr_commit && (dp_addr[3:2] == 2'b00);
    assign wr_pkt    = wr_commit && (dp_addr == 4'd12);
    assign wr_flush  = wr_commit && (dp_addr == 4'd13);

    always_comb begin
        case (dp_size)
            3'd0:    lane_en = 4'b0001 << dp_addr[1:0];
            3'd1:    lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    assign rd_err = complete && !dp_write && (dp_addr[3:2] == 2'b01) &&
                    (lane_en[2] || lane_en[3]);

    assign occ_ext = 32'(buffer_occupancy);

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            reg_bytes[i] = 8'h00;
        end
        reg_bytes[4]  = {7'b0, (ser_state == SER_SEND)};
        reg_bytes[5]  = {6'b0, tx_transfer_active, 1'b0};
        reg_bytes[6]  = {7'b0, err_reg};
        reg_bytes[8]  = occ_ext[7:0];
        reg_bytes[12] = {5'b0, pkt_reg};
        reg_bytes[13] = {7'b0, flush_reg};
    end

    always_comb begin
        hrdata = 32'h0;
        if (dp_legal && !dp_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    hrdata[8*i +: 8] = reg_bytes[{dp_addr[3:2], 2'(i)}];
                end
            end
        end
    end

    // Address/data phase pipeline; an illegal transfer spends one extra cycle
    // with hready low before its second ERROR cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_valid   <= 1'b0;
            dp_err     <= 1'b0;
            err_second <= 1'b0;
            dp_write   <= 1'b0;
            dp_addr    <= 4'd0;
            dp_size    <= 3'd0;
        end else if (hready) begin
            err_second <= 1'b0;
            if (accept) begin
                dp_valid <= 1'b1;
                dp_err   <= is_illegal(haddr, hsize, hwrite);
                dp_write <= hwrite;
                dp_addr  <= haddr;
                dp_size  <= hsize;
            end else begin
                dp_valid <= 1'b0;
                dp_err   <= 1'b0;
            end
        end else if (dp_valid && dp_err) begin
            err_second <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ser_state <= SER_IDLE;
        end else begin
            ser_state <= ser_next;
        end
    end

    always_comb begin
        ser_next      = ser_state;
        store_tx_data = 1'b0;
        tx_data       = 8'h00;
        case (ser_state)
            SER_IDLE: begin
                if (wr_tx) ser_next = SER_SEND;
            end
            SER_SEND: begin
                store_tx_data = store_fire;
                tx_data       = ser_shift[7:0];
                if (wr_tx) begin
                    ser_next = SER_SEND;
                end else if (last_store) begin
                    ser_next = SER_IDLE;
                end
            end
            default: ser_next = SER_IDLE;
        endcase
    end

    // Captured lanes are shifted down so the lowest addressed byte leaves first.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ser_shift <= 32'h0;
            ser_count <= 3'd0;
        end else if (wr_tx) begin
            ser_shift <= hwdata >> {dp_addr[1:0], 3'b000};
            case (dp_size)
                3'd0:    ser_count <= 3'd1;
                3'd1:    ser_count <= 3'd2;
                default: ser_count <= 3'd4;
            endcase
        end else if (store_fire) begin
            ser_shift <= ser_shift >> 8;
            ser_count <= ser_count - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_reg   <= 3'd0;
            flush_reg <= 1'b0;
            err_reg   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            active_q <= tx_transfer_active;

            if (wr_pkt) begin
                pkt_reg <= hwdata[2:0];
            end else if (active_q && !tx_transfer_active) begin
                pkt_reg <= 3'd0;
            end

            if (wr_flush) begin
                flush_reg <= hwdata[8];
            end else if (buffer_occupancy == '0) begin
                flush_reg <= 1'b0;
            end

            if (tx_error) begin
                err_reg <= 1'b1;
            end else if (rd_err) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign clear     = flush_reg;
    assign tx_packet = pkt_reg;
    assign dmode     = tx_transfer_active;

endmodule

// File: tb/tb_ahb_tx_slave_p.sv
// Self-checking bench for ahb_tx_slave_p: vector table, directed multi-cycle
// sequences and randomized transfers against a register-level reference model.
module tb_ahb_tx_slave_p;

    localparam int BUF_DEPTH = 64;
    localparam int OCC_W     = 7;

    logic             clk;
    logic             n_rst;
    logic             hsel;
    logic [3:0]       haddr;
    logic [1:0]       htrans;
    logic [2:0]       hsize;
    logic             hwrite;
    logic [31:0]      hwdata;
    logic [31:0]      hrdata;
    logic             hready;
    logic             hresp;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             tx_transfer_active;
    logic             tx_error;
    logic             store_tx_data;
    logic [7:0]       tx_data;
    logic             clear;
    logic [2:0]       tx_packet;
    logic             dmode;

    int         assertCount = 0;
    int         failCount   = 0;
    int         cycleCnt    = 0;
    logic [7:0] gotQ[$];
    logic [7:0] expQ[$];
    int         gotCyc[$];
    logic [2:0] mPkt;
    logic       mFlush;
    logic       mErr;

    typedef struct {
        logic [3:0]  addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [6:0]  occ;
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[$];

    ahb_tx_slave_p #(.BUF_DEPTH(BUF_DEPTH), .OCC_W(OCC_W)) dut (
        .clk(clk), .n_rst(n_rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .buffer_occupancy(buffer_occupancy),
        .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
        .store_tx_data(store_tx_data), .tx_data(tx_data), .clear(clear),
        .tx_packet(tx_packet), .dmode(dmode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(negedge clk) begin
        if (n_rst && store_tx_data) begin
            gotQ.push_back(tx_data);
            gotCyc.push_back(cycleCnt);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Runs one non-pipelined transfer; called and returns #1 after a rising edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [2:0] s, input logic w,
                                 input logic [31:0] d, output logic [31:0] rd,
                                 output int waits, output logic firstResp,
                                 output logic lastResp);
        int guard;
        hsel = 1'b1; htrans = 2'd2; haddr = a; hsize = s; hwrite = w;
        guard = 0;
        #1;
        while (!hready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = d;
        #1;
        firstResp = hresp;
        waits = 0;
        while (!hready && waits < 50) begin
            waits++;
            @(posedge clk); #2;
        end
        lastResp = hresp;
        rd = hrdata;
        @(posedge clk); #1;
    endtask

    task automatic runCheck(input string name, input logic [3:0] a, input logic [2:0] s,
                            input logic w, input logic [31:0] d, input logic expErr,
                            input logic [31:0] expRd);
        logic [31:0] rd;
        int          waits;
        logic        fr;
        logic        lr;
        applyStimulus(a, s, w, d, rd, waits, fr, lr);
        checkOutput({name, "_waits"}, 32'(waits), expErr ? 32'd1 : 32'd0);
        checkOutput({name, "_hresp1"}, 32'(fr), 32'(expErr));
        checkOutput({name, "_hresp2"}, 32'(lr), 32'(expErr));
        if (!expErr && !w) checkOutput({name, "_hrdata"}, rd, expRd);
    endtask

    task automatic checkBytes(input string name);
        checkOutput({name, "_bytecount"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", name, i), 32'(gotQ[i]), 32'(expQ[i]));
        end
        gotQ.delete();
        expQ.delete();
        gotCyc.delete();
    endtask

    function automatic logic [7:0] modelByte(input int b);
        case (b)
            6:       return {7'b0, mErr};
            8:       return 8'(buffer_occupancy);
            12:      return {5'b0, mPkt};
            13:      return {7'b0, mFlush};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input int a, input int nb);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < nb; j++) r[8*((a+j)%4) +: 8] = modelByte(a + j);
        return r;
    endfunction

    initial begin
        n_rst = 1'b0; hsel = 1'b0; haddr = 4'd0; htrans = 2'd0; hsize = 3'd0;
        hwrite = 1'b0; hwdata = 32'h0; buffer_occupancy = '0;
        tx_transfer_active = 1'b0; tx_error = 1'b0;
        #3;
        checkOutput("rst_hready", 32'(hready), 32'd1);
        checkOutput("rst_hresp", 32'(hresp), 32'd0);
        checkOutput("rst_hrdata", hrdata, 32'h0);
        checkOutput("rst_store", 32'(store_tx_data), 32'd0);
        checkOutput("rst_txdata", 32'(tx_data), 32'd0);
        checkOutput("rst_clear", 32'(clear), 32'd0);
        checkOutput("rst_pkt", 32'(tx_packet), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{4'd8,  3'd0, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0000_0025});
        vecs.push_back('{4'd5,  3'd0, 1'b1, 32'h0000_FF00, 7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd2,  3'd2, 1'b1, 32'h1234_5678, 7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd9,  3'd0, 1'b0, 32'h0,        7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd14, 3'd0, 1'b0, 32'h0,        7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd0,  3'd3, 1'b0, 32'h0,        7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd12, 3'd1, 1'b1, 32'h0000_0007, 7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd1,  3'd1, 1'b0, 32'h0,        7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd8,  3'd0, 1'b1, 32'h0000_0011, 7'd37, 1'b1, 32'h0});
        vecs.push_back('{4'd12, 3'd0, 1'b1, 32'h0000_0005, 7'd37, 1'b0, 32'h0});
        vecs.push_back('{4'd12, 3'd0, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0000_0005});
        vecs.push_back('{4'd13, 3'd0, 1'b1, 32'h0000_0100, 7'd37, 1'b0, 32'h0});
        vecs.push_back('{4'd13, 3'd0, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0000_0100});
        vecs.push_back('{4'd12, 3'd1, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0000_0105});
        vecs.push_back('{4'd0,  3'd2, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0});
        vecs.push_back('{4'd8,  3'd2, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0000_0025});
        vecs.push_back('{4'd4,  3'd1, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0});
        vecs.push_back('{4'd6,  3'd0, 1'b0, 32'h0,        7'd37, 1'b0, 32'h0});

        for (int i = 0; i < vecs.size(); i++) begin
            buffer_occupancy = vecs[i].occ;
            runCheck($sformatf("vec%0d", i), vecs[i].addr, vecs[i].size, vecs[i].write,
                     vecs[i].wdata, vecs[i].expErr, vecs[i].expRdata);
        end
        checkOutput("table_pkt", 32'(tx_packet), 32'd5);
        checkOutput("table_clear", 32'(clear), 32'd1);
        checkBytes("table_nostore");

        buffer_occupancy = '0;
        @(posedge clk); #1;
        checkOutput("flush_selfclear", 32'(clear), 32'd0);

        // Word write drains four consecutive bytes, lowest address first.
        runCheck("req024_wr", 4'd0, 3'd2, 1'b1, 32'h4433_2211, 1'b0, 32'h0);
        expQ = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (6) @(posedge clk); #1;
        checkOutput("req024_span", (gotCyc.size() >= 4) ? 32'(gotCyc[3] - gotCyc[0]) : 32'd99, 32'd3);
        checkBytes("req024");

        // Full buffer pauses the serialiser with the first byte held.
        buffer_occupancy = OCC_W'(BUF_DEPTH);
        runCheck("req025_wr", 4'd2, 3'd1, 1'b1, 32'hBEEF_0000, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("req025_store%0d", k), 32'(store_tx_data), 32'd0);
            checkOutput($sformatf("req025_txdata%0d", k), 32'(tx_data), 32'h0000_00EF);
            @(posedge clk); #1;
        end
        buffer_occupancy = '0;
        expQ = '{8'hEF, 8'hBE};
        repeat (4) @(posedge clk); #1;
        checkBytes("req025");

        // Pipelined word then byte write: second data phase stalls.
        begin
            int waits;
            hsel = 1'b1; htrans = 2'd2; haddr = 4'd0; hsize = 3'd2; hwrite = 1'b1;
            @(posedge clk); #1;
            hwdata = 32'hDDCC_BBAA; haddr = 4'd1; hsize = 3'd0;
            @(posedge clk); #1;
            hsel = 1'b0; htrans = 2'd0; hwdata = 32'h0000_5500;
            #1;
            waits = 0;
            while (!hready && waits < 20) begin
                waits++;
                @(posedge clk); #2;
            end
            checkOutput("req026_resp", 32'(hresp), 32'd0);
            @(posedge clk); #1;
            checkOutput("req026_waits", 32'(waits), 32'd3);
            expQ = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55};
            repeat (6) @(posedge clk); #1;
            checkBytes("req026");
        end

        // Packet register clears after a tx_transfer_active falling edge.
        runCheck("req029_wpkt", 4'd12, 3'd0, 1'b1, 32'h0000_0003, 1'b0, 32'h0);
        tx_transfer_active = 1'b1;
        @(posedge clk); #1;
        checkOutput("req029_dmode1", 32'(dmode), 32'd1);
        runCheck("req029_status", 4'd4, 3'd1, 1'b0, 32'h0, 1'b0, 32'h0000_0200);
        tx_transfer_active = 1'b0;
        #1;
        checkOutput("req029_pkt_hold", 32'(tx_packet), 32'd3);
        @(posedge clk); #1;
        checkOutput("req029_pkt_clr", 32'(tx_packet), 32'd0);
        checkOutput("req029_dmode0", 32'(dmode), 32'd0);

        tx_error = 1'b1;
        @(posedge clk); #1;
        tx_error = 1'b0;
        hsel = 1'b1; htrans = 2'd2; haddr = 4'd6; hsize = 3'd0; hwrite = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; tx_error = 1'b1;
        #1;
        checkOutput("req029_err_rd", hrdata, 32'h0001_0000);
        @(posedge clk); #1;
        tx_error = 1'b0;
        runCheck("req029_err_kept", 4'd6, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0001_0000);
        runCheck("req029_err_clr", 4'd6, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0);

        mPkt = 3'd0; mFlush = 1'b0; mErr = 1'b0;
        buffer_occupancy = 7'd5;
        for (int n = 0; n < 60; n++) begin
            int a, s, sr, nb;
            logic w, illegal;
            logic [31:0] d;
            a  = $urandom_range(0, 15);
            sr = $urandom_range(0, 9);
            s  = (sr == 9) ? 3 : sr % 3;
            if ($urandom_range(0, 3) != 0 && s < 3) a = a - (a % (1 << s));
            nb = 1 << s;
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            illegal = (s > 2) || (a % nb != 0) || (a inside {9, 10, 11, 14, 15}) ||
                      (w && a >= 4 && a <= 8) || (w && (a == 12 || a == 13) && s != 0);
            runCheck($sformatf("rnd%0d", n), 4'(a), 3'(s), w, d, illegal, modelRead(a, nb));
            if (!illegal) begin
                if (w) begin
                    if (a < 4) for (int j = 0; j < nb; j++) expQ.push_back(d[8*((a+j)%4) +: 8]);
                    if (a == 12) mPkt = d[2:0];
                    if (a == 13) mFlush = d[8];
                end else if (a < 8 && a + nb > 6) begin
                    mErr = 1'b0;
                end
            end
            repeat (6) @(posedge clk); #1;
            checkOutput($sformatf("rnd%0d_pkt", n), 32'(tx_packet), 32'(mPkt));
            checkOutput($sformatf("rnd%0d_clear", n), 32'(clear), 32'(mFlush));
        end
        checkBytes("rnd");

        // Asynchronous reset abandons a paused serialisation.
        runCheck("arst_wpkt", 4'd12, 3'd0, 1'b1, 32'h0000_0006, 1'b0, 32'h0);
        buffer_occupancy = OCC_W'(BUF_DEPTH);
        runCheck("arst_wr", 4'd0, 3'd2, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0);
        buffer_occupancy = '0;
        #1;
        checkOutput("arst_pre_store", 32'(store_tx_data), 32'd1);
        n_rst = 1'b0;
        #1;
        checkOutput("arst_store", 32'(store_tx_data), 32'd0);
        checkOutput("arst_txdata", 32'(tx_data), 32'd0);
        checkOutput("arst_pkt", 32'(tx_packet), 32'd0);
        checkOutput("arst_hready", 32'(hready), 32'd1);
        #10 n_rst = 1'b1;
        repeat (8) @(posedge clk); #1;
        checkBytes("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_tx_slave_p.md
AHB_TX_SLAVE_P -- requirements
Module: ahb_tx_slave_p

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 64, meaning data-buffer capacity in bytes.
REQ-002 SHALL have parameter OCC_W, default 7, meaning buffer_occupancy width; 2^OCC_W > BUF_DEPTH.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port n_rst  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have AHB-Lite slave ports: hsel in 1; haddr in 4; htrans in 2; hsize in 3; hwrite in 1; hwdata in 32; hrdata out 32; hready out 1; hresp out 1.
REQ-006 SHALL have buffer ports: buffer_occupancy in OCC_W; tx_transfer_active in 1; tx_error in 1; store_tx_data out 1; tx_data out 8; clear out 1; tx_packet out 3; dmode out 1.

Function
REQ-007 SHALL accept an address phase only when hsel=1, htrans is NONSEQ (2) or SEQ (3) and hready=1; it SHALL register haddr, hsize and hwrite for the data phase.
REQ-008 SHALL flag an accepted transfer as illegal for any of: haddr 9-11 or 14-15; write to 4-8; hsize>2; haddr not aligned to 2^hsize; write to 12-13 with hsize≠0.
REQ-009 SHALL answer an illegal transfer with the two-cycle ERROR response (cycle 1: hresp=1, hready=0; cycle 2: hresp=1, hready=1); no register SHALL change.
REQ-010 SHALL answer legal transfers with hresp=0.
REQ-011 Register map SHALL be: 0-3 TX data (WO); 4-5 status (RO): bit0 serialiser busy, bit9 tx_transfer_active; 6-7 error (RO): bit0 sticky tx_error; 8 occupancy (RO); 12 tx_packet (RW, bits 2:0); 13 flush (RW, bit0).
REQ-012 Read data SHALL be returned little-endian on its natural byte lane: byte at address A on hrdata[8*(A mod 4)+7 : 8*(A mod 4)]; unaddressed lanes 0. Reads of 0-3 SHALL return 0.
REQ-013 A legal write to 0-3 SHALL capture the 2^hsize lanes selected by haddr from hwdata in the data phase and start the serialiser with byte count N=2^hsize.
REQ-014 Serialiser SHALL have states IDLE and SEND; IDLE->SEND on REQ-013; SEND->IDLE after the N-th byte is stored.
REQ-015 In SEND, store_tx_data SHALL be 1 only in cycles where buffer_occupancy < BUF_DEPTH; each such cycle stores one byte, lowest address first; when full it SHALL pause with tx_data held.
REQ-016 tx_data SHALL be 0 in IDLE.
REQ-017 If a transfer to 0-3 is accepted while the serialiser is not IDLE, its data phase SHALL hold hready=0 until the serialiser returns to IDLE, then complete normally; transfers to other addresses SHALL not be stalled.
REQ-018 tx_packet SHALL equal register 12; register 12 SHALL clear to 0 in the cycle after a tx_transfer_active 1->0 edge; a same-cycle software write SHALL take priority.
REQ-019 clear SHALL equal register 13 bit0; register 13 SHALL self-clear when buffer_occupancy=0 and no write to 13 occurs that cycle.
REQ-020 Error bit SHALL set on tx_error=1 and clear on completion of a read of address 6 or 7; a same-cycle tx_error SHALL win.
REQ-021 dmode SHALL equal tx_transfer_active.
REQ-022 When hsel=0 or htrans is IDLE/BUSY, hready SHALL be 1, hresp 0, with no state change.

Reset
REQ-023 On n_rst=0, immediately: all registers 0, serialiser IDLE, hready=1, hresp=0, hrdata=0, store_tx_data=0, tx_data=0, clear=0, tx_packet=0; a serialisation in progress SHALL be abandoned.

Verification
REQ-024 Word write 0x44332211 to addr 0, occupancy 0 -> store_tx_data high 4 consecutive cycles, tx_data 0x11,0x22,0x33,0x44.
REQ-025 Halfword write 0xBEEF to addr 2 with occupancy=BUF_DEPTH for 3 cycles, then lower -> store_tx_data held 0 with tx_data 0xEF for 3 cycles, then 0xEF,0xBE stored.
REQ-026 Word write to 0 immediately followed by byte write to 1 -> second data phase hready=0 for 3 cycles; 5 bytes stored in total.
REQ-027 Write to 5 and unaligned word to 2 -> each gives hresp=1/hready=0, then hresp=1/hready=1; no state change.
REQ-028 Byte read of 8 with occupancy 37 -> hrdata=0x00000025; byte read of 13 -> value on hrdata[15:8].
REQ-029 Write 3 to 12, pulse tx_transfer_active 1 then 0 -> tx_packet=3, then 0 one cycle after the falling edge; tx_error pulse during a read of 6 -> error bit stays 1.
